hazard_ctrl_unit: RTL

//  Hazard controller for the 5-stage RISC-V pipeline. Generates ForwardA_E/ForwardB_E

---
 rtl/hazard_pkg.sv | 16 +
 rtl/fwd_sel.sv | 23 ++
 rtl/hazard_ctrl_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings for the pipeline hazard controller
package hazard_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_e;

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - per-operand forwarding select for the E-stage operand mux
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rs_e_i,
    input  logic [4:0] rd_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       reg_write_m_i,
    input  logic       reg_write_w_i,
    output logic [1:0] fwd_o
);

    // M is the younger producer, so it wins over W when both match
    always_comb begin
        fwd_o = FWD_REG;
        if (reg_write_m_i && (rd_m_i != REG_X0) && (rd_m_i == rs_e_i)) begin
            fwd_o = FWD_MEM;
        end else if (reg_write_w_i && (rd_w_i != REG_X0) && (rd_w_i == rs_e_i)) begin
            fwd_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - forwarding, load-use stall, branch flush and multi-cycle op sequencing
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [4:0]       Rs1_E,
    input  logic [4:0]       Rs2_E,
    input  logic [4:0]       Rd_E,
    input  logic [4:0]       Rd_M,
    input  logic [4:0]       Rd_W,
    input  logic             RegWrite_M,
    input  logic             RegWrite_W,
    input  logic             ResultSrc_E0,
    input  logic             PCSrc_E,
    input  logic             mc_start_E,
    output logic [1:0]       ForwardA_E,
    output logic [1:0]       ForwardB_E,
    output logic             Stall_F,
    output logic             Stall_D,
    output logic             Stall_E,
    output logic             Flush_D,
    output logic             Flush_E,
    output logic             mc_busy,
    output logic             mc_done,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int MC_CNT_W = (MC_LATENCY > 2) ? $clog2(MC_LATENCY) : 1;
    localparam logic [MC_CNT_W-1:0] MC_LOAD = MC_CNT_W'(MC_LATENCY - 2);

    mc_state_e           state_q, state_d;
    logic [MC_CNT_W-1:0] cnt_q, cnt_d;
    logic                mc_done_q, mc_done_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic                mc_stall, busy, lw_stall, branch_flush;

    fwd_sel u_fwd_a (
        .rs_e_i        (Rs1_E),
        .rd_m_i        (Rd_M),
        .rd_w_i        (Rd_W),
        .reg_write_m_i (RegWrite_M),
        .reg_write_w_i (RegWrite_W),
        .fwd_o         (ForwardA_E)
    );

    fwd_sel u_fwd_b (
        .rs_e_i        (Rs2_E),
        .rd_m_i        (Rd_M),
        .rd_w_i        (Rd_W),
        .reg_write_m_i (RegWrite_M),
        .reg_write_w_i (RegWrite_W),
        .fwd_o         (ForwardB_E)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mc_done_d = 1'b0;
        mc_stall  = 1'b0;
        case (state_q)
            MC_IDLE, MC_DONE: begin
                // The start cycle itself is held in E, so a DONE->BUSY restart leaves no gap
                if (mc_start_E) begin
                    state_d  = MC_BUSY;
                    cnt_d    = MC_LOAD;
                    mc_stall = 1'b1;
                end else begin
                    state_d = MC_IDLE;
                end
            end
            MC_BUSY: begin
                mc_stall = 1'b1;
                if (cnt_q == '0) begin
                    state_d   = MC_DONE;
                    mc_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = MC_IDLE;
        endcase
    end

    // E holds the mc op while busy, so its branch/load indications are meaningless then
    assign busy         = (state_q == MC_BUSY);
    assign branch_flush = PCSrc_E && !busy;
    assign lw_stall     = ResultSrc_E0 && (Rd_E != REG_X0) && ((Rd_E == Rs1_D) || (Rd_E == Rs2_D))
                          && !PCSrc_E && !busy;

    assign Stall_F = lw_stall || mc_stall;
    assign Stall_D = lw_stall || mc_stall;
    assign Stall_E = mc_stall;
    assign Flush_D = branch_flush;
    assign Flush_E = branch_flush || lw_stall;

    assign mc_busy      = busy;
    assign mc_done      = mc_done_q;
    assign stall_cycles = stall_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (Stall_F && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= MC_IDLE;
            cnt_q       <= '0;
            mc_done_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mc_done_q   <= mc_done_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
